uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the memory-mapped I/O block. It captures each byte the receiver reports as valid and holds it in a first-word-fall-through queue, so the core can read received data at its own pace. It exposes occupancy, empty/full, a sticky overflow flag and a threshold interrupt to the MMIO register map. Bytes are never lost silently: every dropped byte sets `overflow`.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, ≥ 2.
- `WIDTH`, 8: entry width in bits.
- `THRESHOLD`, 1: `rx_irq` asserts when `count` ≥ `THRESHOLD`; 1 ≤ `THRESHOLD` ≤ `DEPTH`.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  one-cycle strobe from the UART receiver: `in_data` holds a new byte.
- `in_data`  in  WIDTH  received byte.
- `rd_en`  in  1  pop strobe from MMIO, raised when the core reads the RX data register.
- `flush`  in  1  synchronous queue clear from the MMIO control register.
- `clr_overflow`  in  1  clears the sticky overflow flag.
- `rd_data`  out  WIDTH  head entry; 0 when empty.
- `empty`  out  1  queue holds no entries.
- `full`  out  1  queue holds `DEPTH` entries.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky: a byte was dropped.
- `rx_irq`  out  1  `count` ≥ `THRESHOLD`.

## Operation
- **Storage:** a register array of `DEPTH`×`WIDTH`, with write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits wide.
  - Pointers wrap modulo `DEPTH` (natural overflow).
  - `count` is kept as a separate register.
  - The array is not reset.
- **Flag derivation:** `empty` = (`count`==0), `full` = (`count`==`DEPTH`), `rx_irq` = (`count` ≥ `THRESHOLD`). All three are combinational from `count`.
- **Head output:** `rd_data` = `mem[rp]` when `!empty`, else 0. The head is visible without a prior pop (FWFT).
- **Define:**
  - `pop` = `rd_en & !empty`
  - `push` = `in_valid & (!full | pop)`
- **Pop:** `rp` ← `rp`+1. `rd_en` while empty is ignored; no state changes.
- **Push:** `mem[wp]` ← `in_data`, then `wp` ← `wp`+1.
- **Count update:** `count` += `push` − `pop`.
- **Full with simultaneous push and pop:** both occur, `count` stays `DEPTH`, and the new byte lands in the slot just freed.
- **Empty with simultaneous `in_valid` and `rd_en`:** the push occurs, the pop is ignored, and `count` becomes 1.
- **Drop:** `in_valid & full & !pop` discards the byte and sets `overflow`. The queue contents are unchanged.
- **Overflow flag:** `overflow` stays set until `clr_overflow` or `rst`. If a drop and `clr_overflow` occur in the same cycle, set wins.
- **Flush:** `flush` sets `wp`=`rp`=0 and `count`=0.
  - It has priority over push and pop in the same cycle; a concurrent `in_valid` byte is discarded and does **not** set `overflow`.
  - `flush` does not modify `overflow`.
- **Reset:** `rst` behaves as flush and also clears `overflow`.
  - Reset values: `rd_data`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `rx_irq`=0.
  - Reset mid-operation discards all stored bytes.

## Timing
- **Push latency:** 1 cycle. A push at edge N is reflected in `count`/`empty`/`full`/`rx_irq`/`rd_data` right after edge N.
- **Pop latency:** 1 cycle. After the pop edge, `rd_data` shows the next entry, or 0 if the queue became empty.
- **`rd_en` duration:** must be a single-cycle strobe per read. A multi-cycle `rd_en` pops one entry per cycle.
- **Throughput:** one push and one pop per cycle, sustained.
- **Paths:** no combinational path from `in_valid`/`in_data` to any output. `rd_en` affects outputs only after the clock edge.
- **`overflow`:** visible the cycle after the dropping `in_valid`.

## Test plan
- **Reset/FIFO order:** after `rst`, push 0x41, 0x42, 0x43 on separate cycles.
  - Expect `count`=3, `rd_data`=0x41.
  - Three `rd_en` pulses show `rd_data` 0x42, 0x43, then 0 with `empty`=1.
- **Fill and drop:** push 16 bytes 0x00..0x0F, then push 0xAA.
  - Expect `full`=1, `count`=16, `overflow`=1, `rd_data`=0x00.
  - Draining 16 entries yields 0x00..0x0F, with no 0xAA.
- **Full push+pop:** with the queue full of 0x00..0x0F, assert `in_valid` (0x55) and `rd_en` in the same cycle.
  - Expect `count`=16, `overflow`=0, `rd_data`=0x01.
  - The last of 16 drains returns 0x55.
- **Empty corner:** `rd_en` alone on an empty queue leaves `count`=0.
  - Then `in_valid`(0x7E) and `rd_en` together give `count`=1, `rd_data`=0x7E.
- **Flush/clear priority:** with 5 entries and `overflow`=1, assert `flush` together with `in_valid`(0x99).
  - Expect `count`=0, `empty`=1, `overflow` still 1.
  - Next, a drop with `clr_overflow` in the same cycle leaves `overflow`=1; `clr_overflow` alone clears it.
- **Threshold/wrap:** with `THRESHOLD`=4, run 40 interleaved push/pop cycles so the pointers wrap at least twice.
  - `rx_irq` tracks `count`≥4 every cycle.
  - Data order matches a reference queue.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive byte queue between the UART receiver and MMIO: first-word-fall-through,
// with occupancy, full/empty, sticky overflow on dropped bytes and a threshold interrupt.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int THRESHOLD = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       rd_en,
  input  logic                       flush,
  input  logic                       clr_overflow,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       rx_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    count_q;
  logic             overflow_q;

  logic pop;
  logic push;
  logic drop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign rx_irq = (count_q >= CW'(THRESHOLD));
  assign count  = count_q;
  assign overflow = overflow_q;

  assign rd_data = empty ? '0 : mem[rp];

  // A pop on a full queue frees the slot the incoming byte is written into.
  assign pop  = rd_en & ~empty;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (flush) begin
        wp      <= '0;
        rp      <= '0;
        count_q <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
      // A byte discarded by flush is not an overflow; a real drop beats clear.
      if (drop && !flush)
        overflow_q <= 1'b1;
      else if (clr_overflow)
        overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push)
      mem[wp] <= in_data;
  end

endmodule
